// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial two's-complement add/subtract controller.
// One full-adder slice processes one bit per cycle, LSB first; results are
// registered on the MSB cycle and held until the next completion.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr, b_sr, psum;
    logic [CW-1:0]    cnt;
    logic             c;

    logic             s_bit, c_next, last;
    logic [WIDTH-1:0] psum_next;

    // Full-adder slice on the current LSBs; partial sum fills from the MSB side
    // so that after WIDTH shifts bit 0 of the result sits at psum[0].
    assign s_bit     = a_sr[0] ^ b_sr[0] ^ c;
    assign c_next    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign psum_next = {s_bit, psum[WIDTH-1:1]};
    assign last      = (state == RUN) && (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: IDLE waits for start, RUN lasts WIDTH cycles, DONE is one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are flopped from next-state so outputs come straight off registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    // Datapath: operand load on accept, one bit per RUN cycle, result capture on MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            psum <= '0;
            cnt  <= '0;
            c    <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            v    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                // Subtraction as a + ~b + 1: the +1 enters through the carry flop
                a_sr <= a;
                b_sr <= sub ? ~b : b;
                c    <= sub;
                cnt  <= '0;
                psum <= '0;
            end
        end else if (state == RUN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            psum <= psum_next;
            c    <= c_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum  <= psum_next;
                cout <= c_next;
                v    <= c ^ c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_addsub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       v;

    int tests = 0;
    int fails = 0;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from IDLE (called #1 after an edge) and check it.
    // inject >= 0 pulses start with a=b=1 during that RUN cycle index.
    task automatic op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic isub, input int inject, input logic [7:0] es,
                      input logic ec, input logic ev);
        int n;
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_start"}, busy, 1);
        chk({tag, " done_start"}, done, 0);
        n = 0;
        while (!done && n < 20) begin
            if (n == inject) begin
                start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk({tag, " busy_len"}, n, 8);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " v"}, v, ev);
        @(posedge clk); #1;
        chk({tag, " done_clear"}, done, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int t1, t2;
        rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 8'h64; b = 8'h1B;

        // Reset with start asserted: nothing begins
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sum", sum, 8'h00);
        chk("rst cout", cout, 0);
        chk("rst v", v, 0);
        start = 1'b0;
        rst_n = 1'b1;

        op("add_noovf", 8'h64, 8'h1B, 1'b0, -1, 8'h7F, 1'b0, 1'b0);
        op("add_ovf",   8'h64, 8'h1C, 1'b0, -1, 8'h80, 1'b0, 1'b1);
        op("add_wrap",  8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        op("sub_ovf",   8'h80, 8'h01, 1'b1, -1, 8'h7F, 1'b1, 1'b1);
        op("sub_noovf", 8'h05, 8'h07, 1'b1, -1, 8'hFE, 1'b0, 1'b0);
        op("start_busy", 8'h64, 8'h1B, 1'b0, 2, 8'h7F, 1'b0, 1'b0);

        // Back-to-back with start held high: done pulses 10 edges apart
        t1 = -100; t2 = -100;
        a = 8'h64; b = 8'h1B; sub = 1'b0; start = 1'b1;
        for (int k = 1; k <= 40 && t2 < 0; k++) begin
            @(posedge clk); #1;
            chk("b2b no_overlap", busy & done, 0);
            if (done) begin
                if (t1 < 0) t1 = k;
                else begin
                    t2 = k;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b spacing", t2 - t1, 10);
        chk("b2b sum", sum, 8'h7F);
        @(posedge clk); #1;
        chk("b2b idle", busy | done, 0);

        // Abort on the fourth RUN cycle: outputs clear at once, no done
        a = 8'h64; b = 8'h1B; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort sum", sum, 8'h00);
        chk("abort cout", cout, 0);
        chk("abort v", v, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort no_done", done, 0);
        end
        rst_n = 1'b1;
        op("after_abort", 8'h10, 8'h20, 1'b0, -1, 8'h30, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
